// File: rtl/xnor_popcount_acc.sv
// Purpose : per-beat XNOR match count of two WIDTH-bit vectors, accumulated per in_last-delimited frame.
// Latency : the last beat accepted at edge k shows out_valid=1 after edge k+1, at 1 beat/clk.
// Backpr. : in_ready drops only when a last beat sits in S1 while the previous result is still unread.
// Option  : define XNOR_POPCOUNT_MASK_EN to add in_mask, which restricts counting to the masked bits.
module xnor_popcount_acc #(
    parameter int WIDTH  = 8,
    parameter int ACC_W  = 16,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
`ifdef XNOR_POPCOUNT_MASK_EN
    input  logic [WIDTH-1:0]  in_mask,
`endif
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_sat
);

    // Width of one beat's match count (0..WIDTH); ACC_W must be at least this wide.
    localparam int CNT_W = $clog2(WIDTH + 1);

    // S1 state
    logic             r_s1_v;
    logic             r_s1_last;
    logic [CNT_W-1:0] r_s1_m;

    // Frame accumulation state
    logic [ACC_W-1:0]  r_acc;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_sat_f;

    // Held result
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_sum;
    logic [BEAT_W-1:0] r_out_beats;
    logic              r_out_sat;

    logic [WIDTH-1:0]  w_match;
    logic [CNT_W-1:0]  w_pop;
    logic              w_stall;
    logic              w_xfer;
    logic              w_s2_fire;
    logic [ACC_W:0]    w_sum_wide;
    logic              w_clamp;
    logic [ACC_W-1:0]  w_sum_n;
    logic [BEAT_W-1:0] w_beats_n;

`ifdef XNOR_POPCOUNT_MASK_EN
    assign w_match = ~(in_a ^ in_b) & in_mask;
`else
    assign w_match = ~(in_a ^ in_b);
`endif

    // Popcount of the matching bits of the incoming beat.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + CNT_W'(w_match[i]);
        end
    end

    // Only a completed frame can block: its result has nowhere to go while the old one is unread.
    assign w_stall   = r_s1_v && r_s1_last && r_out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign w_xfer    = in_valid && in_ready;
    assign w_s2_fire = r_s1_v && !w_stall;

    // One spare bit catches the accumulator overflow, which is then clamped.
    assign w_sum_wide = {1'b0, r_acc} + (ACC_W + 1)'(r_s1_m);
    assign w_clamp    = w_sum_wide[ACC_W];
    assign w_sum_n    = w_clamp ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
    assign w_beats_n  = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + BEAT_W'(1);

    // S1: capture the match count on transfer, hold while stalled, otherwise drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_m    <= '0;
        end else if (w_xfer) begin
            r_s1_v    <= 1'b1;
            r_s1_last <= in_last;
            r_s1_m    <= w_pop;
        end else if (!w_stall) begin
            r_s1_v    <= 1'b0;
        end
    end

    // S2: accumulate non-last beats; on the last beat clear so the next frame starts with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_sat_f    <= 1'b0;
        end else if (w_s2_fire) begin
            if (r_s1_last) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
                r_sat_f    <= 1'b0;
            end else begin
                r_acc      <= w_sum_n;
                r_beat_cnt <= w_beats_n;
                r_sat_f    <= r_sat_f | w_clamp;
            end
        end
    end

    // Result register: a new frame total may replace a result being read in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_beats <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_s2_fire && r_s1_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum_n;
            r_out_beats <= w_beats_n;
            r_out_sat   <= r_sat_f | w_clamp;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_beats = r_out_beats;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Directed bench for xnor_popcount_acc: an 8-bit instance (ACC_W=6, BEAT_W=4) and a 1-bit instance.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_xnor_popcount_acc;

    logic       clk;
    logic       rst;

    // 8-bit instance signals
    logic       in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
    logic [7:0] in_a, in_b, in_mask;
    logic [5:0] out_sum;
    logic [3:0] out_beats;

    // 1-bit instance signals
    logic       v1, r1, l1, ov1, ordy1, os1;
    logic [0:0] a1, b1, m1;
    logic [5:0] sum1;
    logic [3:0] beats1;

    int vectors;
    int miscompares;

    xnor_popcount_acc #(.WIDTH(8), .ACC_W(6), .BEAT_W(4)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef XNOR_POPCOUNT_MASK_EN
        .in_mask   (in_mask),
`endif
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_sat   (out_sat)
    );

    xnor_popcount_acc #(.WIDTH(1), .ACC_W(6), .BEAT_W(4)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (r1),
        .in_a      (a1),
        .in_b      (b1),
`ifdef XNOR_POPCOUNT_MASK_EN
        .in_mask   (m1),
`endif
        .in_last   (l1),
        .out_valid (ov1),
        .out_ready (ordy1),
        .out_sum   (sum1),
        .out_beats (beats1),
        .out_sat   (os1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [5:0] s,
                           input logic [3:0] n, input logic sat);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".sum"},   64'(out_sum),   64'(s));
        chk({tag, ".beats"}, 64'(out_beats), 64'(n));
        chk({tag, ".sat"},   64'(out_sat),   64'(sat));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        in_valid  = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_mask = 8'hFF;
        out_ready = 1'b1;
        v1 = 1'b0; a1 = '0; b1 = '0; l1 = 1'b0; m1 = 1'b1; ordy1 = 1'b1;

        // Reset state
        #2;
        chk_out("rst0", 1'b0, 6'd0, 4'd0, 1'b0);
        chk("rst0.in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-frame after two 0xFF/0xFF beats
        drive(8'hFF, 8'hFF, 1'b0);
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk_out("rst_mid", 1'b0, 6'd0, 4'd0, 1'b0);
        chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        tick();
        drive(8'h0F, 8'h0F, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("post_rst.lat", 64'(out_valid), 64'd0);
        tick();
        chk_out("post_rst", 1'b1, 6'd8, 4'd1, 1'b0);
        tick();
        chk("post_rst.drain", 64'(out_valid), 64'd0);

        // in_last without in_valid is ignored
        in_last = 1'b1;
        tick();
        tick();
        chk("idle_last", 64'(out_valid), 64'd0);
        in_last = 1'b0;

        // Accumulate: 8 + 0 + 4
        drive(8'hAA, 8'hAA, 1'b0);
        tick();
        drive(8'hAA, 8'h55, 1'b0);
        tick();
        drive(8'hF0, 8'hFF, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("acc.lat", 64'(out_valid), 64'd0);
        tick();
        chk_out("acc", 1'b1, 6'd12, 4'd3, 1'b0);
        tick();
        chk("acc.drain", 64'(out_valid), 64'd0);

        // Saturation: nine beats of 8 matches = 72 -> 63, then a clean zero frame back to back
        for (int i = 0; i < 9; i++) begin
            drive(8'h00, 8'h00, i == 8);
            tick();
        end
        drive(8'hFF, 8'h00, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_out("sat", 1'b1, 6'd63, 4'd9, 1'b1);
        tick();
        chk_out("sat_next", 1'b1, 6'd0, 4'd1, 1'b0);
        tick();
        chk("sat_next.drain", 64'(out_valid), 64'd0);

        // Backpressure: frames of 7, 6, 5 matches with out_ready low
        out_ready = 1'b0;
        drive(8'h01, 8'h00, 1'b1);
        tick();
        drive(8'h03, 8'h00, 1'b1);
        tick();
        drive(8'h07, 8'h00, 1'b1);
        chk_out("bp.first", 1'b1, 6'd7, 4'd1, 1'b0);
        chk("bp.stall", 64'(in_ready), 64'd0);
        tick();
        chk_out("bp.hold", 1'b1, 6'd7, 4'd1, 1'b0);
        chk("bp.hold_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk_out("bp.second", 1'b1, 6'd6, 4'd1, 1'b0);
        tick();
        chk_out("bp.third", 1'b1, 6'd5, 4'd1, 1'b0);
        tick();
        chk("bp.drain", 64'(out_valid), 64'd0);

`ifdef XNOR_POPCOUNT_MASK_EN
        // Mask: only the low nibble counts
        drive(8'h3C, 8'h3C, 1'b1);
        in_mask = 8'h0F;
        tick();
        in_valid = 1'b0;
        in_mask  = 8'hFF;
        tick();
        chk_out("mask", 1'b1, 6'd4, 4'd1, 1'b0);
        tick();
`endif

        // WIDTH=1 truth table, one-beat frames back to back
        v1 = 1'b1; l1 = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        tick();
        a1 = 1'b0; b1 = 1'b1;
        tick();
        chk("w1.00.sum", 64'(sum1), 64'd1);
        chk("w1.00.beats", 64'(beats1), 64'd1);
        a1 = 1'b1; b1 = 1'b0;
        tick();
        chk("w1.01.sum", 64'(sum1), 64'd0);
        chk("w1.01.valid", 64'(ov1), 64'd1);
        a1 = 1'b1; b1 = 1'b1;
        tick();
        chk("w1.10.sum", 64'(sum1), 64'd0);
        v1 = 1'b0;
        tick();
        chk("w1.11.sum", 64'(sum1), 64'd1);
        chk("w1.11.valid", 64'(ov1), 64'd1);
        tick();
        chk("w1.drain", 64'(ov1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
